calc_display: RTL and testbench
===============================

# calc_display

Sequential output stage of the calculator. It sits directly downstream of `calc_top` and consumes its 27-bit binary `digits` result and 2-bit `status`. It converts the value to eight BCD digits with a serial double-dabble engine and drives eight active-low seven-segment displays. Displays update atomically, only after a complete conversion, so the panel never shows a partially converted value.

## Interface
- `NUM_DISP`, default 8: number of seven-segment displays; fixed at 8 for this release.
- `IN_W`, default 27: width of the `digits` input.
- `clock`  in  1: single system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `digits`  in  27: unsigned binary result from `calc_top`.
- `status`  in  2: calculator status from `calc_top`. 2'b01 = ERROR; every other code displays the value normally.
- `displays`  out  [7:0][6:0]: per display, bit order {g,f,e,d,c,b,a}, active-low (0 = segment on). `displays[0]` is the least-significant digit.
- `busy`  out  1: high while a conversion is in flight.

## Operation
- State machine states:
  - IDLE: if `dirty` is set, or `{status,digits}` differs from the stored snapshot, capture `{status,digits}` into the snapshot, load the shift register with `digits`, clear the BCD accumulator (32 bits, 8 nibbles), set `cnt=26`, clear `dirty`, and go to SHIFT.
  - SHIFT: one double-dabble step per cycle. For each nibble ≥5, add 3 to it. Then shift {bcd, bin} left by 1. Decrement `cnt`. Move to COMMIT after the step taken with `cnt==0`, which makes exactly 27 steps.
  - COMMIT: write `displays`, then return to IDLE.
- Commit rules, using the snapshot:
  - status ERROR: `displays[0]`=E (7'b0000110); displays 1..7 blank (7'h7F).
  - Value > 99_999_999: all eight displays show a dash (7'b0111111).
  - Otherwise, each nibble is encoded with leading-zero blanking: nibbles above the most-significant nonzero nibble are blank. A value of 0 shows '0' (7'b1000000) on `displays[0]`, with all others blank.
- Glyphs, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Input changes during SHIFT/COMMIT are ignored. They are detected on the first IDLE cycle afterwards, by comparison against the snapshot.
- Out-of-range check uses the full 27-bit snapshot. The BCD engine still runs all 27 steps, so latency is fixed.

## Timing
- Reset values:
  - state IDLE, `busy`=0, every `displays[i]`=7'h7F, snapshot=0, `dirty`=1.
  - The first post-reset conversion therefore always runs, even when `digits`=0.
- Latency:
  - Call the edge on which the change is detected in IDLE E0.
  - SHIFT occupies edges E1..E27.
  - `displays` take their new value at edge E28 (COMMIT).
  - `busy` is 1 from after E0 through E28, and 0 after E28.
- Minimum spacing between accepted inputs is 29 cycles.
- Back-to-back: if the inputs changed during the conversion, the next detection happens on the edge following E28.
- Reset mid-conversion aborts immediately. Displays blank, and a fresh conversion starts from IDLE on the next cycle.
- `displays` are registered and change only at COMMIT or reset.

## Structure
- `calc_pkg` shared package holds:
  - status codes `ST_ERROR`=2'b01;
  - `MAX_VALUE`=27'd99_999_999;
  - segment constants `SEG_BLANK`, `SEG_DASH`, `SEG_E`;
  - the FSM state enum.
- One sub-module, `seg7_encode`: purely combinational 4-bit BCD → 7-bit active-low glyph. Instantiated 8 times, or used once per nibble in a generate loop.
- `calc_display` contains the FSM, counter, snapshot, double-dabble datapath and blanking logic.

## Test plan
- Reset, inputs `digits`=0, status=00:
  - during reset, all displays are 7'h7F and `busy`=0;
  - after release, `busy` is high for 28 cycles;
  - then `displays[0]`=7'b1000000 and the others are 7'h7F.
- `digits`=12:
  - 28 edges after detection, `displays[0]`=0100100 and `displays[1]`=1111001;
  - displays 2..7 are 7'h7F.
- `digits`=99_999_999 → all eight displays 0010000. Then `digits`=100_000_000 → all eight displays 0111111.
- status=01 with `digits`=5 → `displays[0]`=0000110, others 7'h7F. Then status=00 → `displays[0]`=0010010.
- Input change during conversion:
  - drive 7, then 3 cycles later drive 42;
  - 7 must be displayed first;
  - 42 is displayed 29 cycles after that commit;
  - `busy` drops for exactly one cycle between the two conversions.
- Reset asserted at SHIFT step 10 → displays 7'h7F and `busy`=0 on the next edge. The current value is reconverted after release.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the calculator display stage.
//   ST_ERROR   - status code that replaces the value with an 'E' glyph
//   MAX_VALUE  - largest value that fits on eight decimal digits
//   SEG_*      - active-low {g,f,e,d,c,b,a} glyphs for non-numeric symbols
//   state_t    - conversion FSM states
package calc_pkg;

    localparam logic [1:0]  ST_ERROR  = 2'b01;
    localparam logic [26:0] MAX_VALUE = 27'd99_999_999;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to seven-segment glyph.
//   bcd  in  4 : decimal digit 0..9
//   seg  out 7 : active-low {g,f,e,d,c,b,a}; codes above 9 give a blank glyph
module seg7_encode
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// calc_display: converts the calculator's binary result to decimal with a
// serial double-dabble engine and drives eight active-low seven-segment
// displays. The panel is rewritten only once a full conversion has finished.
//   clock     in  1            : system clock, rising edge
//   reset     in  1            : synchronous, active-high
//   digits    in  IN_W         : unsigned binary value
//   status    in  2            : ST_ERROR shows 'E', any other code shows the value
//   displays  out NUM_DISP x 7 : active-low {g,f,e,d,c,b,a}, [0] = least significant
//   busy      out 1            : conversion in flight
module calc_display
    import calc_pkg::*;
#(
    parameter int NUM_DISP = 8,
    parameter int IN_W     = 27
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [IN_W-1:0]          digits,
    input  logic [1:0]               status,
    output logic [NUM_DISP-1:0][6:0] displays,
    output logic                     busy
);

    localparam int         BCD_W    = 4 * NUM_DISP;
    localparam logic [4:0] CNT_INIT = 5'(IN_W - 1);

    state_t                   state;
    state_t                   state_next;
    logic [4:0]               cnt;
    logic                     dirty;
    logic [1:0]               snap_status;
    logic [IN_W-1:0]          snap_digits;
    logic [IN_W-1:0]          bin;
    logic [BCD_W-1:0]         bcd;
    logic                     start;
    logic [NUM_DISP-1:0][6:0] glyph;
    logic [NUM_DISP-1:0][6:0] disp_next;
    logic [NUM_DISP-1:0]      keep;

    // Add 3 to every nibble of 5 or more so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < NUM_DISP; k++) begin
            if (v[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // A conversion starts after reset (dirty) or whenever the inputs no
    // longer match what was last converted; changes while busy are
    // therefore picked up on the first idle cycle.
    assign start = (state == S_IDLE) &&
                   (dirty || ({status, digits} != {snap_status, snap_digits}));
    assign busy  = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_SHIFT;
            S_SHIFT:  if (cnt == 5'd0) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dirty       <= 1'b1;
            snap_status <= '0;
            snap_digits <= '0;
            displays    <= {NUM_DISP{SEG_BLANK}};
        end else begin
            state <= state_next;
            if (start) begin
                snap_status <= status;
                snap_digits <= digits;
                dirty       <= 1'b0;
                cnt         <= CNT_INIT;
            end else if (state == S_SHIFT) begin
                cnt <= cnt - 5'd1;
            end
            if (state == S_COMMIT)
                displays <= disp_next;
        end
    end

    // Datapath registers are fully reloaded at every start, so they carry
    // no reset.
    always_ff @(posedge clock) begin
        if (start) begin
            bin <= digits;
            bcd <= '0;
        end else if (state == S_SHIFT) begin
            {bcd, bin} <= {dabble_adj(bcd), bin} << 1;
        end
    end

    // Digit i is shown when it or any more significant digit is nonzero;
    // digit 0 is always shown so a zero value displays '0'.
    for (genvar i = 0; i < NUM_DISP; i++) begin : g_digit
        seg7_encode u_enc (
            .bcd (bcd[4*i +: 4]),
            .seg (glyph[i])
        );
        if (i == 0) begin : g_lsd
            assign keep[i] = 1'b1;
        end else begin : g_upper
            assign keep[i] = |bcd[BCD_W-1:4*i];
        end
    end

    // The range test uses the binary snapshot because the BCD register
    // overflows silently for values of nine or more decimal digits.
    always_comb begin
        disp_next = {NUM_DISP{SEG_BLANK}};
        if (snap_status == ST_ERROR) begin
            disp_next[0] = SEG_E;
        end else if (snap_digits > IN_W'(MAX_VALUE)) begin
            disp_next = {NUM_DISP{SEG_DASH}};
        end else begin
            for (int i = 0; i < NUM_DISP; i++) begin
                if (keep[i])
                    disp_next[i] = glyph[i];
            end
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// tb_calc_display: directed vectors with hand-computed panels, checked by a
// scoreboard monitor that compares the displays after every completed
// conversion (falling edge of busy outside reset).
module tb_calc_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] GE = 7'b0000110;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [26:0]     digits = '0;
    logic [1:0]      status = '0;
    logic [7:0][6:0] displays;
    logic            busy;

    int n_vec  = 0;
    int n_miss = 0;
    logic [55:0] exp_q[$];

    calc_display dut (
        .clock    (clock),
        .reset    (reset),
        .digits   (digits),
        .status   (status),
        .displays (displays),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [55:0] mk(input logic [6:0] d7, d6, d5, d4,
                                       input logic [6:0] d3, d2, d1, d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Count consecutive falling edges (starting at the current one) with busy high / low.
    task automatic run_high(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic run_low(output int n);
        n = 0;
        while (busy === 1'b0 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Called on a falling edge with the FSM idle; detection happens on the next rising edge.
    task automatic apply(input string name, input logic [1:0] st, input logic [26:0] v,
                         input logic [55:0] e);
        int n;
        status = st;
        digits = v;
        exp_q.push_back(e);
        @(negedge clock);
        run_high(n);
        check({name, " busy cycles"}, 64'(n), 64'd28);
    endtask

    // Scoreboard monitor
    initial begin
        logic        prev_busy;
        logic [55:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected commit: got %h, required no update", displays);
                end else begin
                    e = exp_q.pop_front();
                    check("panel", 64'(displays), 64'(e));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;

        // Reset with zero input
        repeat (3) @(negedge clock);
        check("reset displays", 64'(displays), 64'({8{BL}}));
        check("reset busy", 64'(busy), 64'd0);
        exp_q.push_back(mk(BL, BL, BL, BL, BL, BL, BL, G0));
        reset = 1'b0;
        @(negedge clock);
        run_high(n);
        check("zero busy cycles", 64'(n), 64'd28);

        apply("12",        2'b00, 27'd12,          mk(BL, BL, BL, BL, BL, BL, G1, G2));
        apply("99999999",  2'b00, 27'd99_999_999,  mk(G9, G9, G9, G9, G9, G9, G9, G9));
        apply("100000000", 2'b00, 27'd100_000_000, mk(DS, DS, DS, DS, DS, DS, DS, DS));
        apply("err big",   2'b01, 27'd100_000_000, mk(BL, BL, BL, BL, BL, BL, BL, GE));
        apply("max27",     2'b00, 27'h7FF_FFFF,    mk(DS, DS, DS, DS, DS, DS, DS, DS));
        apply("err 5",     2'b01, 27'd5,           mk(BL, BL, BL, BL, BL, BL, BL, GE));
        apply("ok 5",      2'b00, 27'd5,           mk(BL, BL, BL, BL, BL, BL, BL, G5));
        apply("10203",     2'b00, 27'd10203,       mk(BL, BL, BL, G1, G0, G2, G0, G3));
        apply("st11 9",    2'b11, 27'd9,           mk(BL, BL, BL, BL, BL, BL, BL, G9));
        apply("st10 0",    2'b10, 27'd0,           mk(BL, BL, BL, BL, BL, BL, BL, G0));

        // Input change during a conversion: 7 first, 42 on the following conversion
        status = 2'b00;
        digits = 27'd7;
        exp_q.push_back(mk(BL, BL, BL, BL, BL, BL, BL, G7));
        @(negedge clock);
        repeat (3) @(negedge clock);
        digits = 27'd42;
        exp_q.push_back(mk(BL, BL, BL, BL, BL, BL, G4, G2));
        run_high(n);
        run_low(g);
        check("idle gap", 64'(g), 64'd1);
        run_high(n);
        check("42 busy cycles", 64'(n), 64'd28);

        // Reset on SHIFT step 10 aborts; value is reconverted after release
        digits = 27'd2024;
        @(negedge clock);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort displays", 64'(displays), 64'({8{BL}}));
        check("abort busy", 64'(busy), 64'd0);
        @(negedge clock);
        exp_q.push_back(mk(BL, BL, BL, BL, G2, G0, G2, G4));
        reset = 1'b0;
        @(negedge clock);
        run_high(n);
        check("2024 busy cycles", 64'(n), 64'd28);

        @(negedge clock);
        check("queue drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
